// File: rtl/sift_kp_pkg.sv
// Shared keypoint definitions for the SIFT detect/filter and reader stages.
// Field positions here must match the words the detect/filter stage writes.
package sift_kp_pkg;

  localparam int KP_AW      = 11;
  localparam int KP_DW      = 19;
  localparam int KP_CW      = 12;
  localparam int KP_ROW_MSB = 18;
  localparam int KP_ROW_LSB = 10;
  localparam int KP_COL_MSB = 9;
  localparam int KP_COL_LSB = 0;
  localparam int KP_ROW_W   = 9;
  localparam int KP_COL_W   = 10;
  localparam int FIFO_DEPTH = 2;

  localparam logic [KP_CW-1:0] KP_MAX_CNT = 12'd2048;

  typedef struct packed {
    logic                scale;
    logic                last;
    logic [KP_ROW_W-1:0] row;
    logic [KP_COL_W-1:0] col;
  } kp_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ1,
    S_READ2,
    S_FLUSH,
    S_DONE
  } kp_rd_state_t;

  function automatic logic [KP_CW-1:0] kp_clamp_cnt(
    input logic [KP_CW-1:0] c
  );
    return (c > KP_MAX_CNT) ? KP_MAX_CNT : c;
  endfunction

  function automatic kp_entry_t kp_make_entry(
    input logic [KP_DW-1:0] w,
    input logic             scale,
    input logic             last
  );
    kp_entry_t e;
    e.scale = scale;
    e.last  = last;
    e.row   = w[KP_ROW_MSB:KP_ROW_LSB];
    e.col   = w[KP_COL_MSB:KP_COL_LSB];
    return e;
  endfunction

endpackage

// File: rtl/kp_skid_fifo.sv
// Two-entry skid FIFO between the keypoint SRAM read path and the output.
// Head entry is presented combinationally; push and pop may coincide.
module kp_skid_fifo
  import sift_kp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  kp_entry_t  din,
  output kp_entry_t  dout,
  output logic [1:0] occ,
  output logic       empty
);

  kp_entry_t mem [FIFO_DEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      full;
  logic      do_push;
  logic      do_pop;

  assign empty   = (occ == 2'd0);
  assign full    = (occ == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/keypoint_reader.sv
// Drains keypoint SRAM bank 1 then bank 2 into a valid/ready stream.
// Reads are only issued when the skid FIFO is guaranteed room for them.
module keypoint_reader
  import sift_kp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KP_CW-1:0] kp1_count,
  input  logic [KP_CW-1:0] kp2_count,
  output logic             busy,
  output logic             done,
  output logic [KP_AW-1:0] keypoint_1_addr,
  output logic             keypoint_1_re,
  input  logic [KP_DW-1:0] keypoint_1_dout,
  output logic [KP_AW-1:0] keypoint_2_addr,
  output logic             keypoint_2_re,
  input  logic [KP_DW-1:0] keypoint_2_dout,
  output logic             kp_valid,
  input  logic             kp_ready,
  output logic [KP_ROW_W-1:0] kp_row,
  output logic [KP_COL_W-1:0] kp_col,
  output logic             kp_scale,
  output logic             kp_last
);

  kp_rd_state_t state;
  kp_rd_state_t nstate;

  logic [KP_CW-1:0] cnt1;
  logic [KP_CW-1:0] cnt2;
  logic [KP_CW-1:0] idx;
  logic [KP_CW-1:0] start_c1;
  logic [KP_CW-1:0] start_c2;

  logic infl_q;
  logic infl_bank_q;
  logic infl_last_q;

  logic issue;
  logic issue_bank;
  logic issue_last;
  logic bank_end;

  logic [1:0] occ;
  logic       fifo_empty;
  logic       pop;
  logic [2:0] load;
  logic       room;

  kp_entry_t push_entry;
  kp_entry_t head;

  assign start_c1 = kp_clamp_cnt(kp1_count);
  assign start_c2 = kp_clamp_cnt(kp2_count);

  assign pop  = kp_valid && kp_ready;
  // Entries that will occupy the FIFO once this cycle's pop retires.
  assign load = {1'b0, occ} - {2'b0, pop} + {2'b0, infl_q};
  assign room = (load < 3'd2);

  // Next-state and read-issue decode.
  always_comb begin
    nstate     = state;
    issue      = 1'b0;
    issue_bank = 1'b0;
    issue_last = 1'b0;
    bank_end   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (start_c1 != '0) begin
            nstate = S_READ1;
          end else if (start_c2 != '0) begin
            nstate = S_READ2;
          end else begin
            // empty pass still walks FLUSH so done lands 2 cycles out
            nstate = S_FLUSH;
          end
        end
      end
      S_READ1: begin
        if (room) begin
          issue = 1'b1;
          if (idx == cnt1 - KP_CW'(1)) begin
            bank_end   = 1'b1;
            issue_last = (cnt2 == '0);
            nstate     = (cnt2 != '0) ? S_READ2 : S_FLUSH;
          end
        end
      end
      S_READ2: begin
        if (room) begin
          issue      = 1'b1;
          issue_bank = 1'b1;
          if (idx == cnt2 - KP_CW'(1)) begin
            bank_end   = 1'b1;
            issue_last = 1'b1;
            nstate     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!infl_q &&
            ((occ == 2'd0) || (occ == 2'd1 && pop))) begin
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Latched counts and the per-bank read index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
      idx  <= '0;
    end else if (state == S_IDLE && start) begin
      cnt1 <= start_c1;
      cnt2 <= start_c2;
      idx  <= '0;
    end else if (issue) begin
      idx <= bank_end ? '0 : idx + KP_CW'(1);
    end
  end

  // One-deep in-flight tracker matching the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_bank_q <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= issue;
      infl_bank_q <= issue_bank;
      infl_last_q <= issue_last;
    end
  end

  assign push_entry = kp_make_entry(
    infl_bank_q ? keypoint_2_dout : keypoint_1_dout,
    infl_bank_q,
    infl_last_q
  );

  kp_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .occ   (occ),
    .empty (fifo_empty)
  );

  assign keypoint_1_re   = issue && !issue_bank;
  assign keypoint_2_re   = issue && issue_bank;
  assign keypoint_1_addr = (state == S_READ1) ? idx[KP_AW-1:0] : '0;
  assign keypoint_2_addr = (state == S_READ2) ? idx[KP_AW-1:0] : '0;

  assign busy = (state == S_READ1) || (state == S_READ2) ||
                (state == S_FLUSH);
  assign done = (state == S_DONE);

  assign kp_valid = !fifo_empty;
  assign kp_row   = head.row;
  assign kp_col   = head.col;
  assign kp_scale = head.scale;
  assign kp_last  = head.last;

endmodule

// File: tb/tb_keypoint_reader.sv
// Scoreboard bench for keypoint_reader with behavioural keypoint SRAMs.
// Stimulus queues expected entries; a monitor pops them on each handshake.
module tb_keypoint_reader;
  import sift_kp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] kp1_count;
  logic [11:0] kp2_count;
  logic        busy;
  logic        done;
  logic [10:0] a1;
  logic        re1;
  logic [18:0] d1;
  logic [10:0] a2;
  logic        re2;
  logic [18:0] d2;
  logic        kp_valid;
  logic        kp_ready;
  logic [8:0]  kp_row;
  logic [9:0]  kp_col;
  logic        kp_scale;
  logic        kp_last;

  keypoint_reader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .kp1_count       (kp1_count),
    .kp2_count       (kp2_count),
    .busy            (busy),
    .done            (done),
    .keypoint_1_addr (a1),
    .keypoint_1_re   (re1),
    .keypoint_1_dout (d1),
    .keypoint_2_addr (a2),
    .keypoint_2_re   (re2),
    .keypoint_2_dout (d2),
    .kp_valid        (kp_valid),
    .kp_ready        (kp_ready),
    .kp_row          (kp_row),
    .kp_col          (kp_col),
    .kp_scale        (kp_scale),
    .kp_last         (kp_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] word1(input logic [10:0] a);
    return {a[10:2], a[1:0], 8'h11};
  endfunction

  function automatic logic [18:0] word2(input logic [10:0] a);
    return {a[10:2] ^ 9'h1FF, a[1:0], 8'hC3};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // SRAM models with out-of-range and per-address read accounting
  int cur_c1;
  int cur_c2;
  int oob;
  int first_a1;
  int rd1_cnt [2048];
  int rd2_cnt [2048];

  always @(posedge clk) begin
    if (re1) begin
      d1 <= word1(a1);
      rd1_cnt[a1] <= rd1_cnt[a1] + 1;
      if (int'(a1) >= cur_c1) oob <= oob + 1;
      if (first_a1 < 0) first_a1 <= int'(a1);
    end
    if (re2) begin
      d2 <= word2(a2);
      rd2_cnt[a2] <= rd2_cnt[a2] + 1;
      if (int'(a2) >= cur_c2) oob <= oob + 1;
    end
  end

  // Scoreboard monitor
  logic [20:0] exp_q [$];
  wire  [20:0] act_w = {kp_scale, kp_last, kp_row, kp_col};
  logic [20:0] held;
  logic [20:0] e;
  bit          prev_stall = 1'b0;
  int          hs_count;
  int          first_hs;
  int          last_hs;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {kp_valid, act_w}, {1'b1, held});
      end
      if (kp_valid && kp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got %0h expected none", act_w);
        end else begin
          e = exp_q.pop_front();
          check("entry", act_w, e);
        end
        if (hs_count == 0) first_hs = cyc;
        last_hs = cyc;
        hs_count++;
      end
      prev_stall = kp_valid && !kp_ready;
      held = act_w;
    end
  end

  int start_cyc;

  task automatic begin_pass(input int c1, input int c2);
    cur_c1 = c1;
    cur_c2 = c2;
    kp1_count = 12'(c1);
    kp2_count = 12'(c2);
    oob = 0;
    first_a1 = -1;
    hs_count = 0;
    for (int i = 0; i < c1; i++)
      exp_q.push_back({1'b0, (i == c1 - 1) && (c2 == 0), word1(11'(i))});
    for (int i = 0; i < c2; i++)
      exp_q.push_back({1'b1, i == c2 - 1, word2(11'(i))});
    start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run(input int maxc, input bit tog, input int inj_a,
                     input int inj_b, output int dcyc, output int fvalid,
                     output int fre);
    dcyc = -1;
    fvalid = -1;
    fre = -1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (fvalid < 0 && kp_valid) fvalid = cyc;
      if (fre < 0 && (re1 || re2)) fre = cyc;
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      start = (cyc == inj_a) || (cyc == inj_b);
      if (start) kp1_count = 12'd7;
      if (tog) kp_ready = ~kp_ready;
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none expected done within %0d", maxc);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int dc, fv, fr, bad;
  bit saw_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    kp1_count = '0;
    kp2_count = '0;
    kp_ready = 1'b0;
    cur_c1 = 0;
    cur_c2 = 0;
    oob = 0;
    first_a1 = -1;
    hs_count = 0;
    for (int i = 0; i < 2048; i++) begin
      rd1_cnt[i] = 0;
      rd2_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", {re1, re2}, 0);
    check("rst_addr", {a1, a2}, 0);
    check("rst_valid", kp_valid, 0);
    check("rst_fields", act_w, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 3 + 2 entries, ready high
    kp_ready = 1'b1;
    begin_pass(3, 2);
    run(100, 0, -1, -1, dc, fv, fr);
    check("t1_first_re", fr, start_cyc + 1);
    check("t1_first_valid", fv, start_cyc + 3);
    check("t1_done_cyc", dc, start_cyc + 8);
    check("t1_done_after_last", dc, last_hs + 1);
    check("t1_count", hs_count, 5);
    check("t1_no_gap", last_hs - first_hs + 1, 5);
    check("t1_q_empty", exp_q.size(), 0);
    check("t1_oob", oob, 0);

    // empty pass
    begin_pass(0, 0);
    run(50, 0, -1, -1, dc, fv, fr);
    check("t2_done_cyc", dc, start_cyc + 2);
    check("t2_no_valid", fv, -1);
    check("t2_no_re", fr, -1);
    check("t2_count", hs_count, 0);

    // 4 + 0, ready toggling
    kp_ready = 1'b1;
    begin_pass(4, 0);
    run(200, 1, -1, -1, dc, fv, fr);
    kp_ready = 1'b1;
    check("t3_count", hs_count, 4);
    check("t3_done_after_last", dc, last_hs + 1);
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_oob", oob, 0);

    // 2048 + 1
    for (int i = 0; i < 2048; i++) begin
      rd1_cnt[i] = 0;
      rd2_cnt[i] = 0;
    end
    begin_pass(2048, 1);
    run(5000, 0, -1, -1, dc, fv, fr);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (rd1_cnt[i] != 1) bad++;
    check("t4_bank1_once", bad, 0);
    check("t4_bank2_addr0", rd2_cnt[0], 1);
    check("t4_count", hs_count, 2049);
    check("t4_no_gap", last_hs - first_hs + 1, 2049);
    check("t4_done_after_last", dc, last_hs + 1);
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_oob", oob, 0);

    // reset mid-pass with the FIFO full
    kp_ready = 1'b0;
    begin_pass(6, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_pre_valid", {kp_valid, busy}, 2'b11);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_valid", kp_valid, 0);
    check("t5_post_busy", busy, 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("t5_no_done", saw_done, 0);
    @(posedge clk);
    #1;
    kp_ready = 1'b1;
    begin_pass(3, 0);
    run(100, 0, -1, -1, dc, fv, fr);
    check("t5_replay_addr0", first_a1, 0);
    check("t5_count", hs_count, 3);
    check("t5_q_empty", exp_q.size(), 0);

    // start while busy and coincident with done
    begin_pass(3, 2);
    run(100, 0, start_cyc + 2, start_cyc + 8, dc, fv, fr);
    check("t6_done_cyc", dc, start_cyc + 8);
    check("t6_count", hs_count, 5);
    check("t6_q_empty", exp_q.size(), 0);
    check("t6_oob", oob, 0);
    @(negedge clk);
    check("t6_idle_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
